// File: rtl/pattern_run_det_pkg.sv
// Shared types and constants for the pattern run detector and related trigger blocks.
//   state_e        : run-qualifier FSM state encoding (2 bits)
//   DefaultPattern : reset value of the programmable pattern for the 6-bit build
//   run_cnt_width  : width of a counter that must hold 0..run_len
package pattern_run_det_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHit  = 2'd2
  } state_e;

  localparam logic [5:0] DefaultPattern = 6'b011011;

  function automatic int unsigned run_cnt_width(input int unsigned run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/pattern_mask_cmp.sv
// Combinational masked equality compare.
//   i_word  : word under test
//   i_pat   : reference pattern
//   i_mask  : 1 = bit compared, 0 = don't care (all zeros always matches)
//   o_match : high when every compared bit of i_word equals i_pat
module pattern_mask_cmp #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] i_word,
  input  logic [W-1:0] i_pat,
  input  logic [W-1:0] i_mask,
  output logic         o_match
);

  assign o_match = ~|((i_word ^ i_pat) & i_mask);

endmodule

// File: rtl/pattern_run_det.sv
// Programmable pattern detector with consecutive-match run qualification.
// Compares {a, b} against a runtime pattern under a mask; a hit is declared after
// RUN_LEN consecutive matching cycles.
//   clk, rst     : clock and synchronous active-high reset (priority over cfg_we, clr)
//   a, b         : upper / lower fields of the compared word
//   cfg_we       : load cfg_pattern / cfg_mask (take effect from the next cycle)
//   cfg_pattern  : new pattern value
//   cfg_mask     : new mask, 1 = compared bit
//   clr          : zero hit_cnt (wins over a simultaneous hit)
//   q            : registered raw match, 1-cycle latency
//   hit          : one-cycle pulse on entering HIT
//   in_hit       : high while in HIT
//   hit_cnt      : saturating count of hit pulses
// Optional build macro PATTERN_RUN_RETRIGGER_EN: while in HIT, a continuing match
// restarts the run count so hit re-pulses every RUN_LEN matching cycles.
module pattern_run_det
  import pattern_run_det_pkg::*;
#(
  parameter int unsigned             A_W     = 3,
  parameter int unsigned             B_W     = 3,
  parameter logic [A_W+B_W-1:0]      PATTERN = (A_W + B_W)'(DefaultPattern),
  parameter int unsigned             RUN_LEN = 1,
  parameter int unsigned             CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               cfg_we,
  input  logic [A_W+B_W-1:0] cfg_pattern,
  input  logic [A_W+B_W-1:0] cfg_mask,
  input  logic               clr,
  output logic               q,
  output logic               hit,
  output logic               in_hit,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam int unsigned    W        = A_W + B_W;
  localparam int unsigned    RW       = run_cnt_width(RUN_LEN);
  localparam logic [RW-1:0]  RunOne   = RW'(1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [W-1:0]     r_pat;
  logic [W-1:0]     r_mask;
  logic             r_q;
  logic             r_hit;
  logic [CNT_W-1:0] r_hit_cnt;
  state_e           r_state;
  state_e           w_state_d;
  logic [RW-1:0]    r_run_cnt;
  logic [RW-1:0]    w_run_cnt_d;
  logic             w_hit_d;
  logic             w_match;
  logic             w_run_done;
  logic [W-1:0]     w_word;

  assign w_word = {a, b};

  pattern_mask_cmp #(
    .W (W)
  ) u_cmp (
    .i_word  (w_word),
    .i_pat   (r_pat),
    .i_mask  (r_mask),
    .o_match (w_match)
  );

  // This cycle's match completes the run of RUN_LEN.
  assign w_run_done = ((32'(r_run_cnt) + 32'd1) == RUN_LEN);

  // Config registers and raw match; compare this cycle still uses the old config.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat  <= PATTERN;
      r_mask <= '1;
      r_q    <= 1'b0;
    end else begin
      if (cfg_we) begin
        r_pat  <= cfg_pattern;
        r_mask <= cfg_mask;
      end
      r_q <= w_match;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_run_cnt <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_run_cnt <= w_run_cnt_d;
      r_hit     <= w_hit_d;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_d   = r_state;
    w_run_cnt_d = r_run_cnt;
    w_hit_d     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_run_cnt_d = '0;
        if (w_match) begin
          if (w_run_done) begin
            w_state_d = StHit;
            w_hit_d   = 1'b1;
          end else begin
            w_state_d   = StRun;
            w_run_cnt_d = RunOne;
          end
        end
      end
      StRun: begin
        if (!w_match) begin
          w_state_d   = StIdle;
          w_run_cnt_d = '0;
        end else if (w_run_done) begin
          w_state_d   = StHit;
          w_run_cnt_d = '0;
          w_hit_d     = 1'b1;
        end else begin
          w_run_cnt_d = r_run_cnt + RunOne;
        end
      end
      StHit: begin
        if (!w_match) begin
          w_state_d   = StIdle;
          w_run_cnt_d = '0;
        end else begin
`ifdef PATTERN_RUN_RETRIGGER_EN
          if (w_run_done) begin
            w_run_cnt_d = '0;
            w_hit_d     = 1'b1;
          end else begin
            w_run_cnt_d = r_run_cnt + RunOne;
          end
`else
          w_run_cnt_d = '0;
`endif
        end
      end
      default: begin
        w_state_d   = StIdle;
        w_run_cnt_d = '0;
      end
    endcase
  end

  // Hit counter counts the registered pulse; clr wins so a coincident hit is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt <= '0;
    end else if (clr) begin
      r_hit_cnt <= '0;
    end else if (r_hit && (r_hit_cnt != '1)) begin
      r_hit_cnt <= r_hit_cnt + CntOne;
    end
  end

  // Outputs.
  always_comb begin
    q       = r_q;
    hit     = r_hit;
    in_hit  = (r_state == StHit);
    hit_cnt = r_hit_cnt;
  end

endmodule

// File: tb/tb_pattern_run_det.sv
module tb_pattern_run_det;

`ifdef PATTERN_RUN_RETRIGGER_EN
  localparam bit Retrig = 1'b1;
`else
  localparam bit Retrig = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] a;
  logic [2:0] b;
  logic       cfg_we;
  logic [5:0] cfg_pattern;
  logic [5:0] cfg_mask;
  logic       clr;

  logic       q1, h1, ih1;
  logic [7:0] c1;
  logic       q3, h3, ih3;
  logic [7:0] c3;
  logic       qs, hs, ihs;
  logic [1:0] cs;
  logic       q2, h2, ih2;
  logic [7:0] c2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_run_det u_d1 (
    .clk (clk), .rst (rst), .a (a), .b (b), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cfg_mask (cfg_mask), .clr (clr),
    .q (q1), .hit (h1), .in_hit (ih1), .hit_cnt (c1)
  );

  pattern_run_det #(.RUN_LEN (3)) u_d3 (
    .clk (clk), .rst (rst), .a (a), .b (b), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cfg_mask (cfg_mask), .clr (clr),
    .q (q3), .hit (h3), .in_hit (ih3), .hit_cnt (c3)
  );

  pattern_run_det #(.CNT_W (2)) u_ds (
    .clk (clk), .rst (rst), .a (a), .b (b), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cfg_mask (cfg_mask), .clr (clr),
    .q (qs), .hit (hs), .in_hit (ihs), .hit_cnt (cs)
  );

  pattern_run_det #(.RUN_LEN (2)) u_d2 (
    .clk (clk), .rst (rst), .a (a), .b (b), .cfg_we (cfg_we),
    .cfg_pattern (cfg_pattern), .cfg_mask (cfg_mask), .clr (clr),
    .q (q2), .hit (h2), .in_hit (ih2), .hit_cnt (c2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] va, input logic [2:0] vb);
    a = va;
    b = vb;
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; cfg_we = 1'b0; cfg_pattern = '0; cfg_mask = '0; clr = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_q", 32'(q1), 32'd0);
    check("rst_hit", 32'(h1), 32'd0);
    check("rst_in_hit", 32'(ih1), 32'd0);
    check("rst_cnt", 32'(c1), 32'd0);

    // 1: single match with defaults
    drive(3'b011, 3'b011);
    step();
    check("t1_q", 32'(q1), 32'd1);
    check("t1_hit", 32'(h1), 32'd1);
    check("t1_in_hit", 32'(ih1), 32'd1);
    check("t1_run3_nohit", 32'(h3), 32'd0);
    drive(3'b000, 3'b000);
    step();
    check("t1_q_drop", 32'(q1), 32'd0);
    check("t1_hit_drop", 32'(h1), 32'd0);
    check("t1_in_hit_drop", 32'(ih1), 32'd0);
    check("t1_cnt", 32'(c1), 32'd1);

    // 2: masked compare; cfg cycle still uses old pattern
    drive(3'b011, 3'b011);
    cfg_we = 1'b1; cfg_pattern = 6'b110000; cfg_mask = 6'b111000;
    step();
    cfg_we = 1'b0;
    check("t2_cfg_cycle_old", 32'(q1), 32'd1);
    for (int i = 0; i < 8; i++) begin
      drive(3'b110, 3'(i));
      step();
      check($sformatf("t2_q_b%0d", i), 32'(q1), 32'd1);
    end
    drive(3'b111, 3'b000);
    step();
    check("t2_q_a111", 32'(q1), 32'd0);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // 3: run qualification, RUN_LEN=3
    drive(3'b011, 3'b011); step(); check("t3_m1_hit", 32'(h3), 32'd0);
    step();
    check("t3_m2_hit", 32'(h3), 32'd0);
    check("t3_m2_in_hit", 32'(ih3), 32'd0);
    drive(3'b000, 3'b000); step(); check("t3_x_in_hit", 32'(ih3), 32'd0);
    drive(3'b011, 3'b011); step();
    step();
    check("t3_m2b_hit", 32'(h3), 32'd0);
    step();
    check("t3_m3_hit", 32'(h3), 32'd1);
    check("t3_m3_in_hit", 32'(ih3), 32'd1);
    step();
    check("t3_m4_hit", 32'(h3), 32'd0);
    check("t3_m4_in_hit", 32'(ih3), 32'd1);
    drive(3'b000, 3'b000); step();
    check("t3_end_in_hit", 32'(ih3), 32'd0);
    check("t3_end_hit", 32'(h3), 32'd0);
    check("t3_cnt", 32'(c3), 32'd1);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // 4: saturation, CNT_W=2
    for (int i = 1; i <= 5; i++) begin
      drive(3'b011, 3'b011); step();
      check($sformatf("t4_hit%0d", i), 32'(hs), 32'd1);
      drive(3'b000, 3'b000); step();
      check($sformatf("t4_cnt%0d", i), 32'(cs), (i < 3) ? 32'(i) : 32'd3);
    end
    drive(3'b011, 3'b011); step();
    check("t4_hit_clr", 32'(hs), 32'd1);
    drive(3'b000, 3'b000);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t4_clr_cnt", 32'(cs), 32'd0);
    step();
    check("t4_clr_lost", 32'(cs), 32'd0);

    // 5: reset mid-run; rst also beats a concurrent cfg_we
    drive(3'b011, 3'b011); step(); step();
    check("t5_pre_hit", 32'(h3), 32'd0);
    rst = 1'b1; cfg_we = 1'b1; cfg_pattern = 6'b000000; cfg_mask = 6'b111111;
    step();
    rst = 1'b0; cfg_we = 1'b0;
    check("t5_rst_q", 32'(q1), 32'd0);
    check("t5_rst_in_hit", 32'(ih3), 32'd0);
    step();
    check("t5_pat_back", 32'(q3), 32'd1);
    check("t5_m1_hit", 32'(h3), 32'd0);
    step();
    check("t5_m2_hit", 32'(h3), 32'd0);
    check("t5_m2_in_hit", 32'(ih3), 32'd0);
    check("t5_cnt", 32'(c3), 32'd0);
    step();
    check("t5_m3_hit", 32'(h3), 32'd1);

    rst = 1'b1;
    drive(3'b000, 3'b000);
    step();
    rst = 1'b0;

    // 6: retrigger behaviour, RUN_LEN=2
    drive(3'b011, 3'b011);
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("t6_hit_m%0d", i), 32'(h2),
            ((i == 2) || (Retrig && (i == 4 || i == 6))) ? 32'd1 : 32'd0);
    end
    drive(3'b000, 3'b000);
    step();
    check("t6_cnt", 32'(c2), Retrig ? 32'd3 : 32'd1);
    check("t6_in_hit_end", 32'(ih2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
